// File: rtl/ypbpr_pkg.sv
// rtl/ypbpr_pkg.sv - shared constants, clamp state enum and saturation helper
// for the YPbPr to RGB converter and its YPBPR_CLAMP_EN black-level clamp.
package ypbpr_pkg;

  localparam int COEF_R_PR     = 359;
  localparam int COEF_G_PB     = 88;
  localparam int COEF_G_PR     = 183;
  localparam int COEF_B_PB     = 454;
  localparam int CHROMA_BIAS   = 128;
  localparam int BLACK_TARGET  = 16;
  localparam int CLAMP_SAMPLES = 16;

  typedef enum logic [1:0] {
    WAIT,
    SAMPLE,
    HOLD
  } clamp_state_t;

  // Rounded sums carry 8 fractional bits; drop them and clip to 0..255.
  function automatic logic [7:0] sat_u8(input logic signed [18:0] v);
    logic signed [18:0] s;
    s = v >>> 8;
    if (s < 19'sd0) return 8'd0;
    else if (s > 19'sd255) return 8'd255;
    else return s[7:0];
  endfunction

endpackage

// File: rtl/ypbpr_black_clamp.sv
// rtl/ypbpr_black_clamp.sv - black-level clamp: averages blanking Y and
// updates the luma offset between lines; used only with YPBPR_CLAMP_EN.
module ypbpr_black_clamp
  import ypbpr_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              de,
  input  logic [7:0]        y,
  output logic signed [8:0] offset
);

  clamp_state_t      state;
  logic              de_q;
  logic [11:0]       acc;
  logic [3:0]        cnt;
  logic signed [8:0] pending;
  logic signed [8:0] offset_q;
  logic [11:0]       acc_next;
  logic              de_rise;
  logic              de_fall;
  logic              load;

  assign acc_next = acc + {4'b0000, y};
  assign de_rise  = de & ~de_q;
  assign de_fall  = ~de & de_q;
  assign load     = en && (state == HOLD) && de_rise;

  // The first pixel of the new line already sees the new offset, so the
  // whole line is converted with one consistent value.
  assign offset = load ? pending : offset_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= WAIT;
      de_q     <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      pending  <= '0;
      offset_q <= '0;
    end else begin
      de_q <= de;
      if (!en) begin
        state <= WAIT;
      end else begin
        case (state)
          WAIT: begin
            if (de_fall) begin
              state <= SAMPLE;
              acc   <= '0;
              cnt   <= '0;
            end
          end
          SAMPLE: begin
            if (de) begin
              state <= WAIT;
            end else begin
              acc <= acc_next;
              cnt <= cnt + 4'd1;
              if (cnt == 4'(CLAMP_SAMPLES - 1)) begin
                pending <= $signed({1'b0, acc_next[11:4]}) - 9'(BLACK_TARGET);
                state   <= HOLD;
              end
            end
          end
          HOLD: begin
            if (de_rise) begin
              offset_q <= pending;
              state    <= WAIT;
            end
          end
          default: state <= WAIT;
        endcase
      end
    end
  end

endmodule

// File: rtl/ypbpr_to_rgb.sv
// rtl/ypbpr_to_rgb.sv - 4-stage YPbPr to RGB converter with bypass; optional
// black-level clamp enabled by YPBPR_CLAMP_EN.
module ypbpr_to_rgb
  import ypbpr_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ypbpr_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        csync,
  input  logic        de,
  input  logic [23:0] din,
  output logic [23:0] dout,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        csync_o,
  output logic        de_o
);

  logic signed [8:0] offset;

`ifdef YPBPR_CLAMP_EN
  ypbpr_black_clamp u_clamp (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (ypbpr_en),
    .de      (de),
    .y       (din[15:8]),
    .offset  (offset)
  );
`else
  assign offset = '0;
`endif

  logic signed [9:0] y_diff;
  logic [7:0]        yc_next;

  assign y_diff = $signed({2'b00, din[15:8]}) - $signed({offset[8], offset});

  always_comb begin
    yc_next = y_diff[7:0];
    if (y_diff < 10'sd0) yc_next = 8'd0;
    else if (y_diff > 10'sd255) yc_next = 8'd255;
  end

  // Mode, syncs and raw pixel travel alongside the arithmetic so the
  // bypass path has exactly the same latency.
  logic              en1, en2, en3;
  logic [3:0]        sync1, sync2, sync3;
  logic [23:0]       raw1, raw2, raw3;
  logic signed [8:0] dpb1, dpr1;
  logic [7:0]        yc1, yc2;
  logic signed [18:0] p_r2, p_gb2, p_gr2, p_b2;
  logic signed [18:0] sum_r3, sum_g3, sum_b3;
  logic signed [18:0] ybase2;

  assign ybase2 = $signed({3'b000, yc2, 8'h00});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en1    <= 1'b0;
      en2    <= 1'b0;
      en3    <= 1'b0;
      sync1  <= '0;
      sync2  <= '0;
      sync3  <= '0;
      raw1   <= '0;
      raw2   <= '0;
      raw3   <= '0;
      dpb1   <= '0;
      dpr1   <= '0;
      yc1    <= '0;
      yc2    <= '0;
      p_r2   <= '0;
      p_gb2  <= '0;
      p_gr2  <= '0;
      p_b2   <= '0;
      sum_r3 <= '0;
      sum_g3 <= '0;
      sum_b3 <= '0;
      dout   <= '0;
      {hsync_o, vsync_o, csync_o, de_o} <= '0;
    end else begin
      en1   <= ypbpr_en;
      sync1 <= {hsync, vsync, csync, de};
      raw1  <= din;
      dpb1  <= $signed({1'b0, din[7:0]}) - 9'(CHROMA_BIAS);
      dpr1  <= $signed({1'b0, din[23:16]}) - 9'(CHROMA_BIAS);
      yc1   <= yc_next;

      en2   <= en1;
      sync2 <= sync1;
      raw2  <= raw1;
      yc2   <= yc1;
      p_r2  <= 19'(dpr1 * COEF_R_PR);
      p_gb2 <= 19'(dpb1 * COEF_G_PB);
      p_gr2 <= 19'(dpr1 * COEF_G_PR);
      p_b2  <= 19'(dpb1 * COEF_B_PB);

      en3    <= en2;
      sync3  <= sync2;
      raw3   <= raw2;
      sum_r3 <= ybase2 + p_r2 + 19'(CHROMA_BIAS);
      sum_g3 <= ybase2 - p_gb2 - p_gr2 + 19'(CHROMA_BIAS);
      sum_b3 <= ybase2 + p_b2 + 19'(CHROMA_BIAS);

      dout <= en3 ? {sat_u8(sum_r3), sat_u8(sum_g3), sat_u8(sum_b3)} : raw3;
      {hsync_o, vsync_o, csync_o, de_o} <= sync3;
    end
  end

endmodule

// File: tb/tb_ypbpr_to_rgb.sv
// tb/tb_ypbpr_to_rgb.sv - scoreboard bench for ypbpr_to_rgb; clamp checks
// follow whether YPBPR_CLAMP_EN is defined.
module tb_ypbpr_to_rgb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ypbpr_en = 1'b0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic        csync = 1'b0;
  logic        de = 1'b0;
  logic [23:0] din = '0;
  logic [23:0] dout;
  logic        hsync_o, vsync_o, csync_o, de_o;

  ypbpr_to_rgb dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ypbpr_en (ypbpr_en),
    .hsync    (hsync),
    .vsync    (vsync),
    .csync    (csync),
    .de       (de),
    .din      (din),
    .dout     (dout),
    .hsync_o  (hsync_o),
    .vsync_o  (vsync_o),
    .csync_o  (csync_o),
    .de_o     (de_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [23:0] dout;
    logic [3:0]  sync;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cur_off = 0;

`ifdef YPBPR_CLAMP_EN
  localparam logic [23:0] BLACK_EXP = 24'h000000;
`else
  localparam logic [23:0] BLACK_EXP = 24'h101010;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] sat(input int v);
    int s;
    s = v >>> 8;
    if (s < 0) return 8'd0;
    if (s > 255) return 8'd255;
    return s[7:0];
  endfunction

  function automatic logic [23:0] model(input logic [23:0] d, input logic en, input int off);
    int y, pb, pr;
    if (!en) return d;
    y  = int'(d[15:8]) - off;
    if (y < 0) y = 0;
    if (y > 255) y = 255;
    pb = int'(d[7:0]) - 128;
    pr = int'(d[23:16]) - 128;
    return {sat(y * 256 + 359 * pr + 128),
            sat(y * 256 - 88 * pb - 183 * pr + 128),
            sat(y * 256 + 454 * pb + 128)};
  endfunction

  task automatic drive_exp(input logic [23:0] d, input logic en, input logic [3:0] syn,
                           input logic [23:0] exp);
    exp_t e;
    din = d;
    ypbpr_en = en;
    {hsync, vsync, csync, de} = syn;
    e.due  = cyc + 4;
    e.dout = exp;
    e.sync = syn;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [23:0] d, input logic en, input logic [3:0] syn);
    drive_exp(d, en, syn, model(d, en, cur_off));
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("rst_dout", {8'h00, dout}, 32'h0);
    check("rst_sync", {28'h0, hsync_o, vsync_o, csync_o, de_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        mon_e = sb.pop_front();
        check("dout", {8'h00, dout}, {8'h00, mon_e.dout});
        check("sync", {28'h0, hsync_o, vsync_o, csync_o, de_o}, {28'h0, mon_e.sync});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    din = 24'hFFFFFF;
    {hsync, vsync, csync, de} = 4'hF;
    ypbpr_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", {8'h00, dout}, 32'h0);
    check("reset_sync", {28'h0, hsync_o, vsync_o, csync_o, de_o}, 32'h0);
    reset_n = 1'b1;

    // Directed vectors with hand-computed results.
    drive_exp(24'h808080, 1'b1, 4'b1001, 24'h808080);
    drive_exp(24'hF0515A, 1'b1, 4'b0101, 24'hEE0E0E);
    drive_exp(24'hFFFF80, 1'b1, 4'b0011, 24'hFFA4FF);
    drive_exp(24'h800000, 1'b1, 4'b1111, 24'h002C00);
    drive_exp(24'h123456, 1'b0, 4'b0001, 24'h123456);

    // Mode toggling every pixel, then random pixels and modes.
    for (int i = 0; i < 12; i++)
      drive(24'($urandom), i[0], {3'(i), 1'b1});
    for (int i = 0; i < 24; i++)
      drive(24'($urandom), 1'($urandom_range(0, 1)), {3'($urandom_range(0, 7)), 1'b1});

    // Full blanking interval of Y=32, then a line at Y=16.
    for (int i = 0; i < 20; i++)
      drive({8'h80, 8'd32, 8'h80}, 1'b1, 4'b1000);
`ifdef YPBPR_CLAMP_EN
    cur_off = 16;
`endif
    drive_exp({8'h80, 8'd16, 8'h80}, 1'b1, 4'b0001, BLACK_EXP);
    for (int i = 0; i < 6; i++)
      drive({8'($urandom), 8'($urandom), 8'($urandom)}, 1'b1, 4'b0001);
    drive_exp({8'h80, 8'd16, 8'h80}, 1'b1, 4'b0001, BLACK_EXP);

    // Short blanking must not touch the offset.
    for (int i = 0; i < 10; i++)
      drive({8'h80, 8'd80, 8'h80}, 1'b1, 4'b1000);
    drive_exp({8'h80, 8'd16, 8'h80}, 1'b1, 4'b0001, BLACK_EXP);
    drive(24'hF0515A, 1'b1, 4'b0001);

    // Reset while the clamp is sampling.
    for (int i = 0; i < 5; i++)
      drive({8'h80, 8'd48, 8'h80}, 1'b1, 4'b1000);
    pulse_reset();
    cur_off = 0;
    drive_exp({8'h80, 8'd16, 8'h80}, 1'b1, 4'b0101, 24'h101010);
    drive_exp(24'hF0515A, 1'b1, 4'b0001, 24'hEE0E0E);
    for (int i = 0; i < 6; i++)
      drive(24'($urandom), 1'b1, 4'b0001);

    repeat (8) @(posedge clk);
    #1;
    check("drain", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
